// File: rtl/div_unit.sv
// Multi-cycle restoring divide/modulo unit with valid/ready handshakes and flush.
// Define DIV_EARLY_OUT_EN to retire |dividend| < |divisor| requests without iterating.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic             op_mod, dvd_neg, quo_neg;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;

  logic             accept, is_signed, src1_neg, src2_neg;
  logic             div_zero, early, shortcut, last;
  logic [WIDTH-1:0] mag1, mag2, short_result;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] rem_next, quo_next, fix_quo, fix_rem, calc_result;

  assign in_ready  = (state == IDLE) && !flush && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign is_signed = ~in_op[0];
  assign src1_neg  = is_signed & in_src1[WIDTH-1];
  assign src2_neg  = is_signed & in_src2[WIDTH-1];
  assign mag1      = src1_neg ? -in_src1 : in_src1;
  assign mag2      = src2_neg ? -in_src2 : in_src2;
  assign div_zero  = (in_src2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && (mag1 < mag2);
`else
  assign early = 1'b0;
`endif

  // Both shortcuts return the raw dividend for modulo; only the quotient differs.
  assign shortcut     = div_zero | early;
  assign short_result = in_op[1] ? in_src1 : (div_zero ? '1 : '0);

  assign rem_shift   = {rem, quo[WIDTH-1]};
  assign trial       = rem_shift - {1'b0, dvs};
  assign rem_next    = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next    = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign last        = (cnt == CW'(WIDTH - 1));
  assign fix_quo     = quo_neg ? -quo_next : quo_next;
  assign fix_rem     = dvd_neg ? -rem_next : rem_next;
  assign calc_result = op_mod ? fix_rem : fix_quo;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = shortcut ? DONE : CALC;
        CALC:    if (last) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The quotient register starts as the dividend magnitude and shifts out one MSB per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_mod     <= 1'b0;
      dvd_neg    <= 1'b0;
      quo_neg    <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      cnt        <= '0;
      out_result <= '0;
    end else if (accept) begin
      op_mod  <= in_op[1];
      dvd_neg <= src1_neg;
      quo_neg <= src1_neg ^ src2_neg;
      quo     <= mag1;
      dvs     <= mag2;
      rem     <= '0;
      cnt     <= '0;
      if (shortcut) out_result <= short_result;
    end else if (state == CALC && !flush) begin
      quo <= quo_next;
      rem <= rem_next;
      cnt <= cnt + CW'(1);
      if (last) out_result <= calc_result;
    end
  end

endmodule
